// File: rtl/rvvi_trace_pkg.sv
// rvvi_trace_pkg: retire record layout and order-tracker state shared by the retire FIFO
package rvvi_trace_pkg;
  parameter int RVVI_XLEN = 64;
  typedef enum logic {UNSYNC, TRACK} trk_state_t;
  typedef struct packed {
    logic [63:0]          order;
    logic [31:0]          insn;
    logic [RVVI_XLEN-1:0] pc;
    logic                 trap;
    logic [1:0]           mode;
    logic                 rd_wb;
    logic [4:0]           rd;
    logic [RVVI_XLEN-1:0] rd_wdata;
  } retire_rec_t;
endpackage

// File: rtl/rvvi_retire_fifo_if.sv
// rvvi_retire_fifo_if: retired-instruction input and buffered-record output of the retire FIFO
interface rvvi_retire_fifo_if #(parameter int XLEN = 64);
  import rvvi_trace_pkg::*;
  logic            in_valid;
  logic [63:0]     in_order;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_pc;
  logic            in_trap;
  logic [1:0]      in_mode;
  logic            in_rd_wb;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_rd_wdata;
  logic            out_valid;
  logic            out_ready;
  retire_rec_t     out_rec;
  modport master (
    output in_valid, in_order, in_insn, in_pc, in_trap, in_mode, in_rd_wb, in_rd, in_rd_wdata, out_ready,
    input  out_valid, out_rec
  );
  modport slave (
    input  in_valid, in_order, in_insn, in_pc, in_trap, in_mode, in_rd_wb, in_rd, in_rd_wdata, out_ready,
    output out_valid, out_rec
  );
endinterface

// File: rtl/rvvi_order_check.sv
// rvvi_order_check: watches retirement order numbers and latches the first sequence gap
module rvvi_order_check
  import rvvi_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] in_order,
  output logic        order_err,
  output logic [63:0] err_exp,
  output logic [63:0] err_got
);
  trk_state_t  state, state_d;
  logic [63:0] exp_q, exp_d, err_exp_d, err_got_d;
  logic        gap, err_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNSYNC;
      exp_q     <= '0;
      order_err <= 1'b0;
      err_exp   <= '0;
      err_got   <= '0;
    end else begin
      state     <= state_d;
      exp_q     <= exp_d;
      order_err <= err_d;
      err_exp   <= err_exp_d;
      err_got   <= err_got_d;
    end
  end
  always_comb state_d = in_valid ? TRACK : state;
  // expected is rebased on every record so one gap does not cascade; 2^64-1 + 1 wraps to 0
  always_comb begin
    gap       = in_valid && state == TRACK && in_order != exp_q;
    exp_d     = in_valid ? in_order + 64'd1 : exp_q;
    err_d     = order_err || gap;
    err_exp_d = (gap && !order_err) ? exp_q : err_exp;
    err_got_d = (gap && !order_err) ? in_order : err_got;
  end
endmodule

// File: rtl/rvvi_retire_fifo.sv
// rvvi_retire_fifo: drop-on-full FIFO of retired-instruction records with order-gap detection
module rvvi_retire_fifo
  import rvvi_trace_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  rvvi_retire_fifo_if.slave      bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_cnt,
  output logic                   order_err,
  output logic [63:0]            err_exp,
  output logic [63:0]            err_got
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  if (XLEN != RVVI_XLEN) begin : g_xlen_chk
    $error("rvvi_retire_fifo XLEN must equal rvvi_trace_pkg::RVVI_XLEN");
  end
  retire_rec_t     mem [DEPTH];
  retire_rec_t     in_rec;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, push, pop, drop;
  assign in_rec = '{order: bus.in_order, insn: bus.in_insn, pc: bus.in_pc, trap: bus.in_trap,
                    mode: bus.in_mode, rd_wb: bus.in_rd_wb, rd: bus.in_rd, rd_wdata: bus.in_rd_wdata};
  // fullness uses the pre-pop count, so a push against a full FIFO drops even while popping
  always_comb begin
    full = count == FULL;
    push = bus.in_valid && !full;
    pop  = bus.out_valid && bus.out_ready;
    drop = bus.in_valid && full;
  end
  assign bus.out_valid = count != '0;
  assign bus.out_rec   = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end
  always_ff @(posedge clk) if (push && !reset) mem[wr_ptr] <= in_rec;
  rvvi_order_check u_order_check (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_order (bus.in_order),
    .order_err(order_err),
    .err_exp  (err_exp),
    .err_got  (err_got)
  );
endmodule

// File: tb/tb_rvvi_retire_fifo.sv
// tb_rvvi_retire_fifo: directed scoreboard bench for the retire FIFO and order tracker
module tb_rvvi_retire_fifo;
  import rvvi_trace_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  count;
  logic [15:0] drop_cnt;
  logic        order_err;
  logic [63:0] err_exp, err_got;
  int          checks = 0;
  int          failures = 0;
  int          mcount = 0;
  retire_rec_t sb[$];
  rvvi_retire_fifo_if #(.XLEN(64)) bus ();
  rvvi_retire_fifo #(.XLEN(64), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .count    (count),
    .drop_cnt (drop_cnt),
    .order_err(order_err),
    .err_exp  (err_exp),
    .err_got  (err_got)
  );
  always #5 clk = ~clk;
  function automatic retire_rec_t mk(input logic [63:0] o);
    retire_rec_t r;
    r.order    = o;
    r.insn     = o[31:0] ^ 32'h0000_0013;
    r.pc       = 64'h8000_0000 + (o << 2);
    r.trap     = o[0];
    r.mode     = o[2:1];
    r.rd_wb    = o[3];
    r.rd       = o[8:4];
    r.rd_wdata = ~o;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit v, input logic [63:0] o, input bit rdy);
    retire_rec_t r;
    r = mk(o);
    bus.in_valid    = v;
    bus.in_order    = r.order;
    bus.in_insn     = r.insn;
    bus.in_pc       = r.pc;
    bus.in_trap     = r.trap;
    bus.in_mode     = r.mode;
    bus.in_rd_wb    = r.rd_wb;
    bus.in_rd       = r.rd;
    bus.in_rd_wdata = r.rd_wdata;
    bus.out_ready   = rdy;
  endtask
  task automatic cyc(input bit v, input logic [63:0] o, input bit rdy);
    retire_rec_t e;
    bit p, q;
    drive(v, o, rdy);
    chk("out_valid", 64'(bus.out_valid), 64'(mcount != 0));
    q = rdy && mcount != 0;
    if (q) begin
      e = sb.pop_front();
      checks++;
      assert (bus.out_rec === e) else begin
        failures++;
        $error("FAIL out_rec got_order=%0h got_pc=%0h exp_order=%0h exp_pc=%0h",
               bus.out_rec.order, bus.out_rec.pc, e.order, e.pc);
      end
    end
    p = v && mcount < 8;
    if (p) sb.push_back(mk(o));
    @(posedge clk);
    #1;
    mcount = mcount + int'(p) - int'(q);
  endtask
  task automatic rst_cycles(input int n);
    reset = 1'b1;
    drive(1'b1, 64'd999, 1'b1);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    sb.delete();
    mcount = 0;
  endtask
  initial begin
    drive(1'b0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    chk("rst_err_exp", err_exp, 64'd0);
    chk("rst_err_got", err_got, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'(i), 1'b0);
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_out_valid", 64'(bus.out_valid), 64'd1);
    chk("fill_head_order", bus.out_rec.order, 64'd0);
    chk("fill_drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(1'b1, 64'd8, 1'b0);
    cyc(1'b1, 64'd9, 1'b0);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_order_err", 64'(order_err), 64'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    rst_cycles(1);
    cyc(1'b1, 64'd5, 1'b1);
    cyc(1'b1, 64'd6, 1'b1);
    chk("gap_none_yet", 64'(order_err), 64'd0);
    cyc(1'b1, 64'd9, 1'b1);
    chk("gap_order_err", 64'(order_err), 64'd1);
    chk("gap_err_exp", err_exp, 64'd7);
    chk("gap_err_got", err_got, 64'd9);
    cyc(1'b1, 64'd12, 1'b1);
    chk("gap2_order_err", 64'(order_err), 64'd1);
    chk("gap2_err_exp", err_exp, 64'd7);
    chk("gap2_err_got", err_got, 64'd9);
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    rst_cycles(1);
    chk("rst2_order_err", 64'(order_err), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 64'(100 + i), 1'b0);
    chk("conc_start_count", 64'(count), 64'd3);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 64'(103 + i), 1'b1);
      chk("conc_count", 64'(count), 64'd3);
    end
    chk("conc_order_err", 64'(order_err), 64'd0);
    rst_cycles(1);
    cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    cyc(1'b1, 64'd0, 1'b1);
    cyc(1'b1, 64'd1, 1'b1);
    chk("wrap_order_err", 64'(order_err), 64'd0);
    cyc(1'b0, 64'd0, 1'b1);
    chk("wrap_count", 64'(count), 64'd0);
    rst_cycles(1);
    for (int i = 0; i < 11; i++) cyc(1'b1, 64'(i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("mid_pre_count", 64'(count), 64'd5);
    chk("mid_pre_drop_cnt", 64'(drop_cnt), 64'd3);
    rst_cycles(1);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_drop_cnt", 64'(drop_cnt), 64'd0);
    cyc(1'b1, 64'd500, 1'b0);
    cyc(1'b1, 64'd501, 1'b0);
    chk("mid_resync_err", 64'(order_err), 64'd0);
    chk("mid_resync_count", 64'(count), 64'd2);
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
